// File: rtl/hazard_control_unit_if.sv
// Pipeline-to-hazard-unit signal bundle: decode/execute/memory observations
// flowing in, stall/flush controls and performance counters flowing out.
interface hazard_control_unit_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic [REG_ADDR_WIDTH-1:0] id_reg_a_addr;
  logic [REG_ADDR_WIDTH-1:0] id_reg_b_addr;
  logic                      id_reg_a_used;
  logic                      id_reg_b_used;
  logic                      ex_mem_rd_en;
  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_addr;
  logic                      ex_branch_taken;
  logic                      dmem_req;
  logic                      dmem_ready;
  logic                      cnt_clear;
  logic                      stall_pc;
  logic                      stall_if_id;
  logic                      stall_id_ex;
  logic                      stall_ex_mem;
  logic                      flush_if_id;
  logic                      flush_id_ex;
  logic [CNT_WIDTH-1:0]      stall_count;
  logic [CNT_WIDTH-1:0]      flush_count;

  // Pipeline side: reports hazards, consumes controls
  modport master (
    output id_reg_a_addr, id_reg_b_addr, id_reg_a_used, id_reg_b_used,
           ex_mem_rd_en, ex_reg_wr_addr, ex_branch_taken,
           dmem_req, dmem_ready, cnt_clear,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, stall_count, flush_count
  );

  // Hazard unit side
  modport slave (
    input  id_reg_a_addr, id_reg_b_addr, id_reg_a_used, id_reg_b_used,
           ex_mem_rd_en, ex_reg_wr_addr, ex_branch_taken,
           dmem_req, dmem_ready, cnt_clear,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard and sequencing controller for the five-stage uDLX pipeline.
// Resolves data-memory freezes, taken-branch squashes and load-use bubbles
// with priority freeze > branch > squash > load_use, and keeps saturating
// stall/flush performance counters.
module hazard_control_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FETCH_LATENCY  = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_control_unit_if.slave bus
);

  typedef enum logic [1:0] {RUN, SQUASH, MEM_WAIT} state_t;

  localparam logic [2:0]           SQ_RELOAD = 3'(FETCH_LATENCY);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_t               state_q, state_d;
  logic [2:0]           sq_left_q, sq_left_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze, branch, squash, load_use, a_hit, b_hit;
  logic stall_pc_c, stall_if_id_c, stall_id_ex_c, stall_ex_mem_c;
  logic flush_if_id_c, flush_id_ex_c;

  // Hazard conditions observed this cycle
  always_comb begin
    freeze   = bus.dmem_req & ~bus.dmem_ready;
    branch   = bus.ex_branch_taken;
    squash   = (state_q == SQUASH);
    a_hit    = bus.id_reg_a_used && (bus.id_reg_a_addr == bus.ex_reg_wr_addr);
    b_hit    = bus.id_reg_b_used && (bus.id_reg_b_addr == bus.ex_reg_wr_addr);
    // r0 is hardwired zero, so a load targeting it never creates a dependency
    load_use = bus.ex_mem_rd_en && (bus.ex_reg_wr_addr != '0) && (a_hit || b_hit);
  end

  // Prioritised control decode; everything is forced quiet while in reset
  always_comb begin
    stall_pc_c     = 1'b0;
    stall_if_id_c  = 1'b0;
    stall_id_ex_c  = 1'b0;
    stall_ex_mem_c = 1'b0;
    flush_if_id_c  = 1'b0;
    flush_id_ex_c  = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        stall_pc_c     = 1'b1;
        stall_if_id_c  = 1'b1;
        stall_id_ex_c  = 1'b1;
        stall_ex_mem_c = 1'b1;
      end else if (branch) begin
        flush_if_id_c  = 1'b1;
        flush_id_ex_c  = 1'b1;
      end else if (squash) begin
        flush_if_id_c  = 1'b1;
      end else if (load_use) begin
        stall_pc_c     = 1'b1;
        stall_if_id_c  = 1'b1;
        flush_id_ex_c  = 1'b1;
      end
    end
  end

  // Next-state logic for the squash / memory-wait sequencer
  always_comb begin
    state_d   = state_q;
    sq_left_d = sq_left_q;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = MEM_WAIT;
        end else if (branch && (SQ_RELOAD != 3'd0)) begin
          state_d   = SQUASH;
          sq_left_d = SQ_RELOAD;
        end
      end
      SQUASH: begin
        // A freeze parks the remaining squash count until memory completes
        if (freeze) begin
          state_d = MEM_WAIT;
        end else if (branch) begin
          sq_left_d = SQ_RELOAD;
        end else begin
          sq_left_d = sq_left_q - 3'd1;
          if (sq_left_q == 3'd1) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (!freeze) begin
          if (branch) begin
            sq_left_d = SQ_RELOAD;
            state_d   = (SQ_RELOAD != 3'd0) ? SQUASH : RUN;
          end else begin
            state_d   = (sq_left_q != 3'd0) ? SQUASH : RUN;
          end
        end
      end
      default: begin
        state_d   = RUN;
        sq_left_d = 3'd0;
      end
    endcase
  end

  // Saturating performance counters; clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_pc_c && (stall_cnt_q != CNT_MAX))
        stall_cnt_d = stall_cnt_q + 1'b1;
      if (branch && !freeze && (flush_cnt_q != CNT_MAX))
        flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      sq_left_q   <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sq_left_q   <= sq_left_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_pc     = stall_pc_c;
  assign bus.stall_if_id  = stall_if_id_c;
  assign bus.stall_id_ex  = stall_id_ex_c;
  assign bus.stall_ex_mem = stall_ex_mem_c;
  assign bus.flush_if_id  = flush_if_id_c;
  assign bus.flush_id_ex  = flush_id_ex_c;
  assign bus.stall_count  = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit. Two instances share stimulus: a
// 16-bit-counter unit for behaviour checks and a 2-bit-counter unit for
// saturation. Control vector order: {stall_pc, stall_if_id, stall_id_ex,
// stall_ex_mem, flush_if_id, flush_id_ex}.
module tb_hazard_control_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0] id_a, id_b, ex_wr;
  logic       a_used, b_used, ex_rd, br, dreq, drdy, clr;

  int tests_run    = 0;
  int tests_failed = 0;

  hazard_control_unit_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) bus_m ();
  hazard_control_unit_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2))  bus_s ();

  assign bus_m.id_reg_a_addr   = id_a;
  assign bus_m.id_reg_b_addr   = id_b;
  assign bus_m.id_reg_a_used   = a_used;
  assign bus_m.id_reg_b_used   = b_used;
  assign bus_m.ex_mem_rd_en    = ex_rd;
  assign bus_m.ex_reg_wr_addr  = ex_wr;
  assign bus_m.ex_branch_taken = br;
  assign bus_m.dmem_req        = dreq;
  assign bus_m.dmem_ready      = drdy;
  assign bus_m.cnt_clear       = clr;

  assign bus_s.id_reg_a_addr   = id_a;
  assign bus_s.id_reg_b_addr   = id_b;
  assign bus_s.id_reg_a_used   = a_used;
  assign bus_s.id_reg_b_used   = b_used;
  assign bus_s.ex_mem_rd_en    = ex_rd;
  assign bus_s.ex_reg_wr_addr  = ex_wr;
  assign bus_s.ex_branch_taken = br;
  assign bus_s.dmem_req        = dreq;
  assign bus_s.dmem_ready      = drdy;
  assign bus_s.cnt_clear       = clr;

  hazard_control_unit #(.REG_ADDR_WIDTH(5), .FETCH_LATENCY(1), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  hazard_control_unit #(.REG_ADDR_WIDTH(5), .FETCH_LATENCY(1), .CNT_WIDTH(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  logic [5:0] ctl, ctl_s;
  assign ctl   = {bus_m.stall_pc, bus_m.stall_if_id, bus_m.stall_id_ex,
                  bus_m.stall_ex_mem, bus_m.flush_if_id, bus_m.flush_id_ex};
  assign ctl_s = {bus_s.stall_pc, bus_s.stall_if_id, bus_s.stall_id_ex,
                  bus_s.stall_ex_mem, bus_s.flush_if_id, bus_s.flush_id_ex};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    id_a = 5'd0; id_b = 5'd0; ex_wr = 5'd0;
    a_used = 1'b0; b_used = 1'b0; ex_rd = 1'b0; br = 1'b0;
    dreq = 1'b0; drdy = 1'b1; clr = 1'b0;
  endtask

  task automatic clear_counters;
    idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    // Every hazard asserted at once: outputs must still be quiet in reset
    id_a = 5'd3; a_used = 1'b1; ex_rd = 1'b1; ex_wr = 5'd3;
    br = 1'b1; dreq = 1'b1; drdy = 1'b0; clr = 1'b0;
    b_used = 1'b0; id_b = 5'd0;
    #1;
    tests_run++;
    if (ctl !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000000);
    end
    tick();
    tick();
    tests_run++;
    if (bus_m.stall_count !== 16'd0 || bus_m.flush_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_counts: got stall=%0d flush=%0d expected 0/0",
               bus_m.stall_count, bus_m.flush_count);
    end
    idle();
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (ctl !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_idle_ctl: got %b expected %b", ctl, 6'b000000);
    end
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_load_use;
    clear_counters();
    // Load to r3 in EX, decode reads r3 on A
    ex_rd = 1'b1; ex_wr = 5'd3; id_a = 5'd3; a_used = 1'b1; id_b = 5'd5; b_used = 1'b1;
    #1;
    tests_run++;
    if (ctl !== 6'b110001) begin
      tests_failed++;
      $display("FAIL lu_a_ctl: got %b expected %b", ctl, 6'b110001);
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (ctl !== 6'b000000 || bus_m.stall_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL lu_release: got ctl=%b stall_count=%0d expected 000000/1", ctl, bus_m.stall_count);
    end
    tick();
    // Same sequence targeting r0: no dependency
    ex_rd = 1'b1; ex_wr = 5'd0; id_a = 5'd0; a_used = 1'b1;
    #1;
    tests_run++;
    if (ctl !== 6'b000000) begin
      tests_failed++;
      $display("FAIL lu_r0_ctl: got %b expected %b", ctl, 6'b000000);
    end
    tick();
    // Match on source B only
    ex_rd = 1'b1; ex_wr = 5'd7; id_a = 5'd3; a_used = 1'b1; id_b = 5'd7; b_used = 1'b1;
    #1;
    tests_run++;
    if (ctl !== 6'b110001 || bus_m.stall_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL lu_b: got ctl=%b stall_count=%0d expected 110001/1", ctl, bus_m.stall_count);
    end
    tick();
    // Address matches but the operand is not read
    ex_rd = 1'b1; ex_wr = 5'd7; id_a = 5'd7; a_used = 1'b0; id_b = 5'd7; b_used = 1'b0;
    #1;
    tests_run++;
    if (ctl !== 6'b000000 || bus_m.stall_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL lu_unused: got ctl=%b stall_count=%0d expected 000000/2", ctl, bus_m.stall_count);
    end
    tick();
    idle();
    $display("[TB] test_load_use done");
  endtask

  task automatic test_branch;
    logic [5:0] exp_ctl [3] = '{6'b000011, 6'b000010, 6'b000000};
    bit         br_seq  [3] = '{1'b1, 1'b0, 1'b0};
    clear_counters();
    for (int i = 0; i < 3; i++) begin
      idle();
      br = br_seq[i];
      #1;
      tests_run++;
      if (ctl !== exp_ctl[i]) begin
        tests_failed++;
        $display("FAIL branch_cyc%0d: got %b expected %b", i, ctl, exp_ctl[i]);
      end
      tick();
    end
    tests_run++;
    if (bus_m.flush_count !== 16'd1 || bus_m.stall_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL branch_counts: got flush=%0d stall=%0d expected 1/0",
               bus_m.flush_count, bus_m.stall_count);
    end
    $display("[TB] test_branch done");
  endtask

  task automatic test_freeze;
    clear_counters();
    for (int i = 0; i < 4; i++) begin
      idle();
      dreq = 1'b1; drdy = 1'b0;
      #1;
      tests_run++;
      if (ctl !== 6'b111100) begin
        tests_failed++;
        $display("FAIL freeze_cyc%0d: got %b expected %b", i, ctl, 6'b111100);
      end
      tick();
    end
    idle();
    dreq = 1'b1; drdy = 1'b1;
    #1;
    tests_run++;
    if (ctl !== 6'b000000 || bus_m.stall_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL freeze_release: got ctl=%b stall_count=%0d expected 000000/4", ctl, bus_m.stall_count);
    end
    tick();
    idle();
    tick();
    $display("[TB] test_freeze done");
  endtask

  task automatic test_branch_freeze;
    bit         br_seq  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bit         fr_seq  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [5:0] exp_ctl [6] = '{6'b000011, 6'b111100, 6'b111100,
                                6'b000000, 6'b000010, 6'b000000};
    clear_counters();
    for (int i = 0; i < 6; i++) begin
      idle();
      br   = br_seq[i];
      dreq = fr_seq[i];
      drdy = ~fr_seq[i];
      #1;
      tests_run++;
      if (ctl !== exp_ctl[i]) begin
        tests_failed++;
        $display("FAIL br_freeze_cyc%0d: got %b expected %b", i, ctl, exp_ctl[i]);
      end
      tick();
    end
    tests_run++;
    if (bus_m.flush_count !== 16'd1 || bus_m.stall_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL br_freeze_counts: got flush=%0d stall=%0d expected 1/2",
               bus_m.flush_count, bus_m.stall_count);
    end
    $display("[TB] test_branch_freeze done");
  endtask

  task automatic test_branch_load_use;
    bit         br_seq  [3] = '{1'b1, 1'b0, 1'b0};
    bit         lu_seq  [3] = '{1'b1, 1'b1, 1'b0};
    logic [5:0] exp_ctl [3] = '{6'b000011, 6'b000010, 6'b000000};
    clear_counters();
    for (int i = 0; i < 3; i++) begin
      idle();
      br = br_seq[i];
      ex_rd = lu_seq[i]; ex_wr = 5'd9; id_a = 5'd9; a_used = 1'b1;
      #1;
      tests_run++;
      if (ctl !== exp_ctl[i]) begin
        tests_failed++;
        $display("FAIL br_lu_cyc%0d: got %b expected %b", i, ctl, exp_ctl[i]);
      end
      tick();
    end
    tests_run++;
    if (bus_m.stall_count !== 16'd0 || bus_m.flush_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL br_lu_counts: got stall=%0d flush=%0d expected 0/1",
               bus_m.stall_count, bus_m.flush_count);
    end
    idle();
    $display("[TB] test_branch_load_use done");
  endtask

  task automatic test_back_to_back;
    bit         br_seq  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [5:0] exp_ctl [4] = '{6'b000011, 6'b000011, 6'b000010, 6'b000000};
    clear_counters();
    for (int i = 0; i < 4; i++) begin
      idle();
      br = br_seq[i];
      #1;
      tests_run++;
      if (ctl !== exp_ctl[i]) begin
        tests_failed++;
        $display("FAIL b2b_cyc%0d: got %b expected %b", i, ctl, exp_ctl[i]);
      end
      tick();
    end
    tests_run++;
    if (bus_m.flush_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL b2b_count: got flush=%0d expected 2", bus_m.flush_count);
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_saturation;
    clear_counters();
    for (int i = 0; i < 5; i++) begin
      idle();
      dreq = 1'b1; drdy = 1'b0;
      tick();
    end
    idle();
    #1;
    tests_run++;
    if (bus_s.stall_count !== 2'd3) begin
      tests_failed++;
      $display("FAIL sat_stall: got %0d expected 3", bus_s.stall_count);
    end
    tests_run++;
    if (bus_m.stall_count !== 16'd5) begin
      tests_failed++;
      $display("FAIL wide_stall: got %0d expected 5", bus_m.stall_count);
    end
    // Clear in the same cycle as a stall: clear wins
    dreq = 1'b1; drdy = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    tests_run++;
    if (bus_s.stall_count !== 2'd0 || bus_m.stall_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL clear_wins: got sat=%0d wide=%0d expected 0/0",
               bus_s.stall_count, bus_m.stall_count);
    end
    tick();
    idle();
    #1;
    tests_run++;
    if (bus_s.stall_count !== 2'd1) begin
      tests_failed++;
      $display("FAIL post_clear_inc: got %0d expected 1", bus_s.stall_count);
    end
    tick();
    $display("[TB] test_saturation done");
  endtask

  task automatic test_reset_mid;
    clear_counters();
    // Reset while a squash is pending
    br = 1'b1;
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (ctl !== 6'b000000) begin
      tests_failed++;
      $display("FAIL rst_squash_ctl: got %b expected %b", ctl, 6'b000000);
    end
    tick();
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (ctl !== 6'b000000 || bus_m.flush_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL rst_squash_after: got ctl=%b flush=%0d expected 000000/0", ctl, bus_m.flush_count);
    end
    tick();
    // Reset while parked in MEM_WAIT
    dreq = 1'b1; drdy = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (ctl_s !== 6'b000000 || ctl !== 6'b000000) begin
      tests_failed++;
      $display("FAIL rst_wait_ctl: got %b expected %b", ctl, 6'b000000);
    end
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    tests_run++;
    if (ctl !== 6'b000000 || bus_m.stall_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL rst_wait_after: got ctl=%b stall=%0d expected 000000/0", ctl, bus_m.stall_count);
    end
    tick();
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_freeze();
    test_branch_freeze();
    test_branch_load_use();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard and sequencing controller for the five-stage uDLX core. Watches decode source registers, the instruction in execute, the branch decision leaving execute and the data-memory handshake in the memory stage. Drives stall and flush controls into the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers. Keeps saturating stall and flush counters for performance analysis.

## Interface
- REG_ADDR_WIDTH, 5, register address width
- FETCH_LATENCY, 1, extra cycles IF/ID is flushed after a taken branch (range 0..7)
- CNT_WIDTH, 16, width of each performance counter
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_reg_a_addr  in  REG_ADDR_WIDTH  decode source A address
- id_reg_b_addr  in  REG_ADDR_WIDTH  decode source B address
- id_reg_a_used  in  1  decode instruction reads source A
- id_reg_b_used  in  1  decode instruction reads source B
- ex_mem_rd_en  in  1  instruction in execute is a load
- ex_reg_wr_addr  in  REG_ADDR_WIDTH  destination of instruction in execute
- ex_branch_taken  in  1  execute redirects fetch (taken branch or jump)
- dmem_req  in  1  memory stage holds a data access
- dmem_ready  in  1  data memory completes access this cycle
- cnt_clear  in  1  synchronous clear of both counters
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID register
- stall_id_ex  out  1  hold ID/EX register
- stall_ex_mem  out  1  hold EX/MEM register
- flush_if_id  out  1  load bubble into IF/ID
- flush_id_ex  out  1  load bubble into ID/EX
- stall_count  out  CNT_WIDTH  cycles with stall_pc=1
- flush_count  out  CNT_WIDTH  taken-branch events

## Operation
- Control outputs are combinational from the registered state and the current inputs. Counters and state are registered.
- Definitions:
  - freeze = dmem_req & !dmem_ready
  - load_use = ex_mem_rd_en & ex_reg_wr_addr!=0 & ((id_reg_a_used & id_reg_a_addr==ex_reg_wr_addr) | (id_reg_b_used & id_reg_b_addr==ex_reg_wr_addr))
- Priority per cycle: freeze > branch > squash > load_use.
- Freeze: all four stall_* = 1, both flush_* = 0.
- Branch (ex_branch_taken, no freeze): flush_if_id = 1, flush_id_ex = 1, no stalls. A load_use in the same cycle is ignored.
- Squash (state SQUASH, no freeze, no new branch): flush_if_id = 1 only.
- Load_use (alone): stall_pc = 1, stall_if_id = 1, flush_id_ex = 1 (bubble).
- FSM states: RUN, SQUASH, MEM_WAIT. Counter sq_left is 3 bits.
  - RUN: freeze -> MEM_WAIT. Else branch & FETCH_LATENCY>0 -> SQUASH with sq_left=FETCH_LATENCY. Else stay.
  - SQUASH: freeze -> MEM_WAIT, sq_left held. Else branch -> reload sq_left=FETCH_LATENCY. Else decrement; on the cycle sq_left==1 -> RUN.
  - MEM_WAIT: stays while freeze.
    - On the first cycle without freeze, branch and load_use rules apply normally.
    - Return target: SQUASH if sq_left!=0 or a branch is taken that cycle, else RUN.
- Counters:
  - stall_count increments every cycle stall_pc=1.
  - flush_count increments every cycle ex_branch_taken causes a flush.
  - Both saturate at all-ones.
  - cnt_clear zeroes both and wins over increment.

## Timing
- Reset (rst_n=0 at edge): state RUN, sq_left=0, both counters 0. All stall_*/flush_* are 0 while in reset, regardless of inputs.
- Load-use costs exactly 1 bubble cycle; the load leaves execute the next cycle, clearing the condition.
- Taken branch costs 1+FETCH_LATENCY flushed IF/ID cycles and 1 flushed ID/EX cycle.
- Freeze response is zero-latency, same cycle as dmem_ready=0.
- Reset mid-SQUASH or mid-MEM_WAIT: returns to RUN the next cycle; the pending squash is discarded.

## Test plan
- Load writing r3 in EX, decode reads r3 on A -> one cycle of stall_pc=stall_if_id=flush_id_ex=1, stall_count=1. Same sequence with r0 -> no stall.
- Taken branch, FETCH_LATENCY=1 -> cycle 0: flush_if_id=flush_id_ex=1; cycle 1: flush_if_id only; cycle 2: RUN, flush_count=1.
- dmem_req=1 with dmem_ready=0 for 4 cycles -> all stalls high for 4 cycles, flushes 0, stall_count=4.
- Branch, then freeze on the SQUASH cycle for 2 cycles -> flush_if_id suppressed; after ready, one SQUASH cycle resumes, then RUN.
- Branch and load_use in the same cycle -> flushes only, no stall_pc.
- Counter saturation with CNT_WIDTH=2: 5 stall cycles -> stall_count=3. cnt_clear together with a stall -> 0. rst_n low mid-sequence -> outputs 0, counters 0.
